// File: rtl/iso14443a_pkg.sv
// Shared ISO/IEC 14443A types and defaults: transmitter states, load-modulation
// sequences and the 106 kbit/s timing constants.
package iso14443a_pkg;

    localparam int BIT_TICKS_106K        = 128;
    localparam int SC_HALF_TICKS_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE,
        SOC,
        DATA,
        EOC
    } tx_state_t;

    typedef enum logic [1:0] {
        SEQ_D,
        SEQ_E,
        SEQ_F
    } lm_seq_t;

    // True when the given half of a bit period carries the subcarrier.
    function automatic logic seq_modulated(input lm_seq_t seq, input logic second_half);
        case (seq)
            SEQ_D:   return !second_half;
            SEQ_E:   return second_half;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/subcarrier_gen.sv
// fc/(2*SC_HALF_TICKS) subcarrier phase counter. `sc` is the subcarrier level
// for the upcoming cycle so the parent can register it straight into lm_out.
module subcarrier_gen #(
    parameter int SC_HALF_TICKS = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    input  logic enable,
    output logic sc
);

    localparam int             CW      = $clog2(2 * SC_HALF_TICKS);
    localparam logic [CW-1:0]  PH_LAST = CW'(2 * SC_HALF_TICKS - 1);
    localparam logic [CW-1:0]  PH_HALF = CW'(SC_HALF_TICKS);

    logic [CW-1:0] phase_reg;
    logic [CW-1:0] phase_next;

    always_comb begin
        phase_next = phase_reg;
        if (restart) begin
            phase_next = '0;
        end else if (enable) begin
            phase_next = (phase_reg == PH_LAST) ? '0 : phase_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_reg <= '0;
        end else begin
            phase_reg <= phase_next;
        end
    end

    assign sc = (phase_next < PH_HALF);

endmodule

// File: rtl/load_modulation_tx.sv
// ISO/IEC 14443A PICC load-modulation transmitter: frames bits with SOC/EOC and
// Manchester-encodes them onto an OOK subcarrier driving the load switch.
module load_modulation_tx
    import iso14443a_pkg::*;
#(
    parameter int BIT_TICKS     = BIT_TICKS_106K,
    parameter int SC_HALF_TICKS = SC_HALF_TICKS_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic tx_data,
    input  logic tx_last,
    input  logic tx_valid,
    output logic tx_ready,
    output logic lm_out,
    output logic busy,
    output logic underflow
);

    localparam int            TW     = $clog2(BIT_TICKS);
    localparam logic [TW-1:0] T_LAST = TW'(BIT_TICKS - 1);
    localparam logic [TW-1:0] T_HALF = TW'(BIT_TICKS / 2);

    tx_state_t     state_reg, state_next;
    logic [TW-1:0] t_reg, t_next;
    logic          bit_reg, bit_next;
    logic          last_reg, last_next;
    logic          lm_out_reg;
    logic          t_end;
    logic          sc_next, sc_restart, sc_enable;
    lm_seq_t       seq_next;

    assign t_end = (t_reg == T_LAST);

    always_comb begin
        state_next = state_reg;
        t_next     = t_end ? '0 : t_reg + 1'b1;
        bit_next   = bit_reg;
        last_next  = last_reg;
        tx_ready   = 1'b0;
        underflow  = 1'b0;
        case (state_reg)
            IDLE: begin
                t_next   = '0;
                tx_ready = 1'b1;
                if (tx_valid) begin
                    bit_next   = tx_data;
                    last_next  = tx_last;
                    state_next = SOC;
                end
            end
            SOC: begin
                if (t_end) state_next = DATA;
            end
            DATA: begin
                if (t_end) begin
                    if (last_reg) begin
                        state_next = EOC;
                    end else begin
                        // Next bit is requested only in the final tick of the current one.
                        tx_ready = 1'b1;
                        if (tx_valid) begin
                            bit_next  = tx_data;
                            last_next = tx_last;
                        end else begin
                            underflow  = 1'b1;
                            state_next = EOC;
                        end
                    end
                end
            end
            EOC: begin
                if (t_end) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        seq_next = SEQ_F;
        case (state_next)
            SOC:     seq_next = SEQ_D;
            DATA:    seq_next = bit_next ? SEQ_D : SEQ_E;
            default: seq_next = SEQ_F;
        endcase
    end

    // Subcarrier phase realigns so every modulated half begins with the load on.
    assign sc_restart = (t_next == '0) || (t_next == T_HALF);
    assign sc_enable  = (state_next != IDLE);

    subcarrier_gen #(
        .SC_HALF_TICKS(SC_HALF_TICKS)
    ) u_subcarrier_gen (
        .clk    (clk),
        .rst    (rst),
        .restart(sc_restart),
        .enable (sc_enable),
        .sc     (sc_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            t_reg      <= '0;
            bit_reg    <= 1'b0;
            last_reg   <= 1'b0;
            lm_out_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            t_reg      <= t_next;
            bit_reg    <= bit_next;
            last_reg   <= last_next;
            lm_out_reg <= sc_next && seq_modulated(seq_next, t_next >= T_HALF);
        end
    end

    assign lm_out = lm_out_reg;
    assign busy   = (state_reg != IDLE);

endmodule

// File: tb/tb_load_modulation_tx.sv
// Directed bench for load_modulation_tx: a PCD-side lm_out monitor decodes each
// bit period into D/E/F and frame timing is checked against hand-derived values.
module tb_load_modulation_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] tx_data, tx_last, tx_valid;
    wire  [1:0] tx_ready, lm_out, busy, underflow;

    always #5 clk = ~clk;

    load_modulation_tx #(.BIT_TICKS(128), .SC_HALF_TICKS(8)) dut0 (
        .clk(clk), .rst(rst), .tx_data(tx_data[0]), .tx_last(tx_last[0]),
        .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]), .lm_out(lm_out[0]),
        .busy(busy[0]), .underflow(underflow[0])
    );

    load_modulation_tx #(.BIT_TICKS(64), .SC_HALF_TICKS(4)) dut1 (
        .clk(clk), .rst(rst), .tx_data(tx_data[1]), .tx_last(tx_last[1]),
        .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]), .lm_out(lm_out[1]),
        .busy(busy[1]), .underflow(underflow[1])
    );

    int    tests = 0;
    int    fails = 0;
    logic  lm_buf [0:4095];
    int    busy_cnt, uf_cnt, uf_cyc, ready_cnt, idle_cyc, wait_cyc;
    string dec;

    task automatic check_int(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
        $display("[TB] %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic check_str(input string tag, input string obs, input string exp);
        tests++;
        assert (obs == exp) else begin
            fails++;
            $error("FAIL %s: observed %s expected %s", tag, obs, exp);
        end
        $display("[TB] %s observed=%s expected=%s", tag, obs, exp);
    endtask

    // PCD-side monitor: classify one bit period of captured lm_out as D, E, F or '?'.
    function automatic string decode_period(input int base, input int bt, input int sh);
        bit   sub1 = 1, zero1 = 1, sub2 = 1, zero2 = 1;
        logic v, sc;
        for (int i = 0; i < bt; i++) begin
            v  = lm_buf[base + i];
            sc = ((i % (2 * sh)) < sh);
            if (i < bt / 2) begin
                if (v !== sc)   sub1  = 0;
                if (v !== 1'b0) zero1 = 0;
            end else begin
                if (v !== sc)   sub2  = 0;
                if (v !== 1'b0) zero2 = 0;
            end
        end
        if (sub1 && zero2)  return "D";
        if (zero1 && sub2)  return "E";
        if (zero1 && zero2) return "F";
        return "?";
    endfunction

    // Sends one frame on instance u, capturing lm_out from the SOC start until the first
    // IDLE cycle. Called just after a posedge, or at an IDLE negedge when chained.
    task automatic run_frame(input int u, input int bt, input int sh,
                             input logic [15:0] data, input int nbits,
                             input int drop_at, input bit chained, input bit chain_next);
        int k = 0;
        int c = 0;
        bit hs = 1;
        bit done = 0;
        tx_data[u]  = data[0];
        tx_last[u]  = (nbits == 1);
        tx_valid[u] = 1'b1;
        wait_cyc = 0;
        if (!chained) @(negedge clk);
        while (!(tx_ready[u] && tx_valid[u]) && wait_cyc < 10) begin
            wait_cyc++;
            @(negedge clk);
        end
        busy_cnt = 0; uf_cnt = 0; uf_cyc = -1; ready_cnt = 0; idle_cyc = -1;
        while (!done && c < 20 * bt) begin
            @(posedge clk);
            #1;
            if (hs) begin
                k++;
                if (k < nbits && k != drop_at) begin
                    tx_data[u] = data[k];
                    tx_last[u] = (k == nbits - 1);
                end else if (chain_next && k >= nbits) begin
                    tx_data[u]  = 1'b1;
                    tx_last[u]  = 1'b1;
                    tx_valid[u] = 1'b1;
                end else begin
                    tx_valid[u] = 1'b0;
                end
            end
            @(negedge clk);
            c++;
            if (!busy[u]) begin
                idle_cyc = c;
                done = 1;
            end else begin
                lm_buf[c - 1] = lm_out[u];
                busy_cnt++;
                if (tx_ready[u]) ready_cnt++;
            end
            if (underflow[u]) begin
                uf_cnt++;
                uf_cyc = c;
            end
            hs = tx_ready[u] && tx_valid[u] && busy[u];
        end
        dec = "";
        for (int p = 0; p < busy_cnt / bt; p++) dec = {dec, decode_period(p * bt, bt, sh)};
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int highs;
        rst = 1'b1;
        tx_data = '0; tx_last = '0; tx_valid = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_int("reset_lm_out",    int'(lm_out[0]),    0);
        check_int("reset_busy",      int'(busy[0]),      0);
        check_int("reset_underflow", int'(underflow[0]), 0);
        check_int("reset_tx_ready",  int'(tx_ready[0]),  1);
        check_int("reset_tx_ready_small", int'(tx_ready[1]), 1);

        // Frame 0x93, LSB first, tx_valid held high.
        @(posedge clk); #1;
        run_frame(0, 128, 8, 16'h0093, 8, -1, 0, 0);
        check_str("f93_seq",       dec, "DDDEEDEEDF");
        check_int("f93_wait",      wait_cyc,  0);
        check_int("f93_busy",      busy_cnt,  1280);
        check_int("f93_idle",      idle_cyc,  1281);
        check_int("f93_underflow", uf_cnt,    0);
        check_int("f93_ready",     ready_cnt, 7);

        // Single-bit frame.
        @(posedge clk); #1;
        run_frame(0, 128, 8, 16'h0001, 1, -1, 0, 0);
        check_str("single_seq",   dec, "DDF");
        check_int("single_ready", ready_cnt, 0);
        check_int("single_idle",  idle_cyc,  385);

        // tx_valid dropped before the third bit's ready cycle.
        @(posedge clk); #1;
        run_frame(0, 128, 8, 16'b00101, 5, 3, 0, 0);
        check_int("uf_count", uf_cnt,   1);
        check_int("uf_cycle", uf_cyc,   512);
        check_str("uf_seq",   dec,      "DDEDF");
        check_int("uf_idle",  idle_cyc, 641);
        check_int("uf_ready", ready_cnt, 3);

        // Reset at t=40 of bit 0 (a logic 1, modulated first half).
        @(posedge clk); #1;
        tx_data[0] = 1'b1; tx_last[0] = 1'b0; tx_valid[0] = 1'b1;
        @(negedge clk);
        check_int("rst_accept_ready", int'(tx_ready[0]), 1);
        @(posedge clk); #1;
        tx_valid[0] = 1'b0;
        repeat (168) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check_int("rst_busy_before", int'(busy[0]), 1);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_int("rst_lm_out",   int'(lm_out[0]),   0);
        check_int("rst_busy",     int'(busy[0]),     0);
        check_int("rst_tx_ready", int'(tx_ready[0]), 1);
        highs = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (lm_out[0]) highs++;
        end
        check_int("rst_lm_quiet", highs, 0);
        @(posedge clk); #1;
        run_frame(0, 128, 8, 16'h0000, 1, -1, 0, 0);
        check_str("rst_new_seq",  dec,      "DEF");
        check_int("rst_new_idle", idle_cyc, 385);

        // Reduced timing: 64 clocks per bit, fc/8 subcarrier.
        @(posedge clk); #1;
        run_frame(1, 64, 4, 16'h0093, 8, -1, 0, 0);
        check_str("small_seq",  dec,      "DDDEEDEEDF");
        check_int("small_busy", busy_cnt, 640);
        check_int("small_idle", idle_cyc, 641);

        // Back-to-back frames: second frame accepted on the first IDLE cycle.
        @(posedge clk); #1;
        run_frame(0, 128, 8, 16'b01, 2, -1, 0, 1);
        check_str("b2b_first_seq",  dec,      "DDEF");
        check_int("b2b_first_idle", idle_cyc, 513);
        check_int("b2b_ready_idle", int'(tx_ready[0] && tx_valid[0]), 1);
        run_frame(0, 128, 8, 16'h0001, 1, -1, 1, 0);
        check_int("b2b_wait",     wait_cyc,       0);
        check_int("b2b_phase_hi", int'(lm_buf[0]), 1);
        check_str("b2b_seq",      dec,            "DDF");
        check_int("b2b_idle",     idle_cyc,       385);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
